// File: rtl/ula_md_pkg.sv
// Shared encodings for the EX-stage ALU and its multiply/divide unit.
// Latency: n/a (constants, types and helper functions only).
// Backpressure: n/a.
package ula_md_pkg;

    // Combinational ALU operation codes (OP port)
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_SLLV = 4'hB;
    localparam logic [3:0] OP_SRLV = 4'hC;
    localparam logic [3:0] OP_SRAV = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;

    // Multiply/divide operation codes (md_op port)
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // Bit 1 of md_op selects divide, bit 0 selects unsigned.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ula_md_md_unit.sv
// Iterative multiply/divide unit with HI/LO registers (shift-add / restoring divide).
// Latency: start sampled at edge 0, hi/lo written at edge WIDTH+1, md_done high the cycle after.
// Backpressure: md_busy high in RUN/FIX; md_start and MTHI/MTLO ignored while busy.
//
// Ports: clk, rst_n; op_a/op_b operands (rs/rt); md_start, md_op request;
//        hi_we/lo_we MT writes of op_a; md_busy, md_done status; hi, lo registers.
module ula_md_md_unit
    import ula_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);

    md_state_t          state, state_nxt;
    logic [SHW-1:0]     cnt;
    // Multiply: {partial product high, multiplier being shifted out}.
    // Divide:   {partial remainder, dividend being shifted in as quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;          // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;        // product / quotient must be negated
    logic               neg_r;        // remainder must be negated
    logic               div0;

    logic               idle_like;
    logic               start_ok;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;

    // DONE is not busy, so a new request can chain straight off a finished one.
    assign idle_like = (state == MD_IDLE) || (state == MD_DONE);
    assign start_ok  = md_start && idle_like;
    assign md_busy   = (state == MD_RUN) || (state == MD_FIX);
    assign md_done   = (state == MD_DONE);

    assign a_neg = md_is_signed(md_op) && op_a[WIDTH-1];
    assign b_neg = md_is_signed(md_op) && op_b[WIDTH-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (md_start) state_nxt = MD_RUN;
            MD_RUN:  if (cnt == SHW'(WIDTH-1)) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_DONE;
            MD_DONE: state_nxt = md_start ? MD_RUN : MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One iteration step. For divide the shifted remainder needs WIDTH+1 bits;
    // a borrow out of div_diff means the divisor did not fit (restore).
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb};
        acc_step  = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_diff[WIDTH])
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction. A zero divisor leaves the dividend magnitude as remainder,
    // so re-applying the dividend sign returns the original operand in hi.
    // MIN / -1 falls out naturally: negating MIN wraps back to MIN.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        q_fix    = div0 ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_res   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = is_div ? q_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                cnt    <= '0;
                is_div <= md_is_div(md_op);
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                div0   <= md_is_div(md_op) && (op_b == '0);
                if (md_is_div(md_op)) begin
                    acc <= {{WIDTH{1'b0}}, a_mag};
                    opb <= b_mag;
                end else begin
                    acc <= {{WIDTH{1'b0}}, b_mag};
                    opb <= a_mag;
                end
            end else if (state == MD_RUN) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The result write in FIX cannot coincide with an MT write: MT is only
    // honoured in IDLE/DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == MD_FIX) begin
            hi <= hi_res;
            lo <= lo_res;
        end else if (idle_like) begin
            if (hi_we) hi <= op_a;
            if (lo_we) lo <= op_a;
        end
    end

endmodule

// File: rtl/ula_md.sv
// EX-stage ALU: single-cycle combinational ALU plus iterative multiply/divide with HI/LO.
// Latency: result/Zero_Flag combinational; multiply/divide WIDTH+2 cycles to md_done.
// Backpressure: md_busy stalls the pipeline; requests while busy are dropped.
//
// Ports: clk, rst_n; In1, In2, OP -> result, Zero_Flag;
//        md_start, md_op, hi_we, lo_we -> md_busy, md_done, hi, lo.
module ula_md
    import ula_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [3:0]       OP,
    output logic [WIDTH-1:0] result,
    output logic             Zero_Flag,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh_amt;

    // Immediate and variable shifts share one datapath: In1 carries either
    // shamt or rs, the decoder upstream has already chosen.
    assign sh_amt = In1[SHW-1:0];

    always_comb begin
        result = '0;
        case (OP)
            OP_ADD:  result = In1 + In2;
            OP_SUB:  result = In1 - In2;
            OP_AND:  result = In1 & In2;
            OP_OR:   result = In1 | In2;
            OP_XOR:  result = In1 ^ In2;
            OP_NOR:  result = ~(In1 | In2);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (In1 < In2)};
            OP_SLL, OP_SLLV: result = In2 << sh_amt;
            OP_SRL, OP_SRLV: result = In2 >> sh_amt;
            OP_SRA, OP_SRAV: result = WIDTH'($signed(In2) >>> sh_amt);
            OP_JR:   result = In1;
            default: result = '0;
        endcase
    end

    assign Zero_Flag = (result == '0);

    ula_md_md_unit #(.WIDTH(WIDTH)) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_a     (In1),
        .op_b     (In2),
        .md_start (md_start),
        .md_op    (md_op),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: doc/ula_md.md
Name: ula_md

Overview:
Parametrised successor of the single-cycle ULA. It keeps the full combinational ALU path (same 4-bit OP encoding, `result` and `Zero_Flag` in the same cycle). It adds a sequential multiply/divide unit with HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO. The block sits in the EX stage of the MIPS datapath. The control unit stalls the pipeline on `md_busy`; MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32, datapath width (power of two, ≥8). Localparam SHW = $clog2(WIDTH) is the shift-amount width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- In1  in  WIDTH  operand 1 (rs / shamt for shifts)
- In2  in  WIDTH  operand 2 (rt)
- OP  in  4  combinational ALU operation code
- result  out  WIDTH  combinational ALU result
- Zero_Flag  out  1  high when result == 0
- md_start  in  1  start request for the multiply/divide unit
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- hi_we  in  1  MTHI: hi <= In1
- lo_we  in  1  MTLO: lo <= In1
- md_busy  out  1  unit is occupied
- md_done  out  1  one-cycle pulse: hi/lo hold the final result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Combinational path, unchanged semantics:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6 (signed), SLTU 7.
  - SLL 8, SRL 9, SRA A, SLLV B, SRLV C, SRAV D: all shift In2 by In1[SHW-1:0].
  - JR E passes In1; F gives 0.
  - All operations are WIDTH bits and wrap modulo 2^WIDTH.
- Reset (async, rst_n=0):
  - state=IDLE; hi=lo=0; md_busy=0; md_done=0; iteration counter=0.
  - Reset mid-operation discards the operation; no partial write reaches hi/lo.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE: md_start=1 sampled at an edge → RUN. At that edge, latch the operand magnitudes (absolute values for signed ops), the result-sign flags and md_op; counter=0.
  - RUN: exactly WIDTH cycles, one bit per cycle. Multiply is radix-2 shift-add into a 2×WIDTH accumulator; divide is restoring shift-subtract. On the WIDTH-th edge → FIX.
  - FIX: one cycle applying sign correction. Quotient is negated if the operand signs differ; remainder takes the dividend's sign; 2×WIDTH product is negated if the signs differ. Edge → DONE, writing hi/lo at that edge.
  - DONE: md_done=1 for this one cycle; next edge → IDLE.
- Latency: start sampled at edge 0 → md_done high in the cycle following edge WIDTH+1 (34 cycles for WIDTH=32). Latency is fixed and identical for every md_op and every operand value.
- md_busy = (state == RUN or FIX). It is 0 in DONE, so a new md_start is accepted in the DONE cycle (back-to-back operation).
- md_start while busy is ignored; the running operation is unaffected.
- Results:
  - MULT/MULTU: {hi, lo} = full 2×WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder (truncating toward zero).
- Divide by zero: lo = all ones, hi = dividend (In1 as latched). Same latency, no exception.
- Signed overflow (DIV of MIN by −1): lo = MIN, hi = 0.
- hi_we/lo_we:
  - Honoured only when state is IDLE or DONE; ignored while busy.
  - If asserted in the same cycle as an accepted md_start, the MT write happens and the later operation result overwrites it.
  - hi_we and lo_we together are both honoured.
- hi/lo are stable and readable at all times except at the FIX→DONE write edge.

Decomposition:
- Shared package/header (extends ula_opcodes.vh): ULA OP codes (ADD…JR), MD_OP codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), FSM state encodings.
- One natural sub-module: md_unit (FSM + iterative mul/div + hi/lo). Top ula_md = combinational ALU + md_unit.

Test Plan (WIDTH=32):
- MULT In1=FFFFFFFD (−3), In2=00000007 → md_done at cycle 34; hi=FFFFFFFF, lo=FFFFFFEB; md_busy high in cycles 1–33.
- MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001; a second md_start issued in the DONE cycle is accepted, and its md_done arrives 34 cycles later.
- DIV FFFFFFF9 (−7) / 00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000 / FFFFFFFF → lo=80000000, hi=00000000.
- DIVU 00000064 / 00000000 → lo=FFFFFFFF, hi=00000064, latency still 34.
- Busy rules: md_start pulsed and hi_we=1 with In1=12345678 during RUN → both ignored, final result unchanged. In IDLE, hi_we=lo_we=1 with In1=0000ABCD → hi=lo=0000ABCD next edge.
- Async reset: rst_n dropped at cycle 10 of a DIV → hi=lo=0, md_busy=0, no md_done. Separately, combinational sweep: SRA In2=80000000, In1=4 → result F8000000, Zero_Flag=0; SUB 5−5 → Zero_Flag=1.
